// File: rtl/game_state_regs.sv
// Game state register file: score/fruits/lives, frame countdown, sequential BCD score.
// Optional best-score tracking is built when HISCORE_EN is defined.
module game_state_regs #(
    parameter logic [31:0] TIME_FRAMES = 32'd3600,
    parameter int          SCORE_W     = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               restart,
    input  logic               frame_clk,
    input  logic               timer_en,
    input  logic               Load_S,
    input  logic               Load_F,
    input  logic               Load_L,
    input  logic [SCORE_W-1:0] score_to_reg,
    input  logic [3:0]         fruits_to_reg,
    input  logic [7:0]         lives_to_reg,
    input  logic               win,
    input  logic               lose,
    output logic [SCORE_W-1:0] score_from_reg,
    output logic [3:0]         fruits_from_reg,
    output logic [1:0]         lives_from_reg,
    output logic [31:0]        counter,
    output logic [15:0]        score_bcd,
    output logic               bcd_busy,
    output logic [SCORE_W-1:0] hiscore
);

    localparam int SR_W  = 16 + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W) + 1;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_t;

    bcd_state_t bcd_state, bcd_state_nxt;

    logic              clear;
    logic              fclk_s1, fclk_s2;
    logic              tick;
    logic [SR_W-1:0]   shift_reg;
    logic [SR_W-1:0]   shift_adj;
    logic [CNT_W-1:0]  shift_cnt;
    logic [SCORE_W-1:0] last_val;
    logic              pending;
    logic              score_changed;
    logic              start_conv;

    assign clear = Reset | restart;
    assign tick  = fclk_s1 & ~fclk_s2;

    // Game registers: restart takes priority over any same-cycle load.
    always_ff @(posedge Clk) begin
        if (clear) begin
            score_from_reg  <= '0;
            fruits_from_reg <= '0;
            lives_from_reg  <= '0;
        end else begin
            if (Load_S) score_from_reg  <= score_to_reg;
            if (Load_F) fruits_from_reg <= fruits_to_reg;
            if (Load_L) lives_from_reg  <= (lives_to_reg > 8'd3) ? 2'd3 : lives_to_reg[1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            fclk_s1 <= 1'b0;
            fclk_s2 <= 1'b0;
            counter <= TIME_FRAMES;
        end else begin
            fclk_s1 <= frame_clk;
            fclk_s2 <= fclk_s1;
            if (tick && timer_en && counter != 32'd0)
                counter <= counter - 32'd1;
        end
    end

    function automatic logic [15:0] dabble_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign shift_adj     = {dabble_adjust(shift_reg[SR_W-1 -: 16]), shift_reg[SCORE_W-1:0]};
    assign score_changed = (score_from_reg != last_val);
    assign bcd_busy      = (bcd_state != BCD_IDLE);

    always_comb begin
        bcd_state_nxt = bcd_state;
        start_conv    = 1'b0;
        case (bcd_state)
            BCD_IDLE: begin
                if (score_changed) begin
                    start_conv    = 1'b1;
                    bcd_state_nxt = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                if (shift_cnt == CNT_W'(SCORE_W - 1))
                    bcd_state_nxt = BCD_DONE;
            end
            BCD_DONE: begin
                // Chain straight into the next conversion if the score moved meanwhile.
                if (pending || score_changed) begin
                    start_conv    = 1'b1;
                    bcd_state_nxt = BCD_SHIFT;
                end else begin
                    bcd_state_nxt = BCD_IDLE;
                end
            end
            default: bcd_state_nxt = BCD_IDLE;
        endcase
        if (restart) begin
            bcd_state_nxt = BCD_IDLE;
            start_conv    = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            bcd_state <= BCD_IDLE;
            shift_reg <= '0;
            shift_cnt <= '0;
            last_val  <= '0;
            pending   <= 1'b0;
            score_bcd <= '0;
        end else begin
            bcd_state <= bcd_state_nxt;
            if (bcd_state == BCD_DONE)
                score_bcd <= shift_reg[SR_W-1 -: 16];
            if (start_conv) begin
                shift_reg <= {16'd0, score_from_reg};
                shift_cnt <= '0;
                last_val  <= score_from_reg;
                pending   <= 1'b0;
            end else if (bcd_state == BCD_SHIFT) begin
                shift_reg <= {shift_adj[SR_W-2:0], 1'b0};
                shift_cnt <= shift_cnt + CNT_W'(1);
                if (score_changed)
                    pending <= 1'b1;
            end
        end
    end

`ifdef HISCORE_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            hiscore <= '0;
        else if (!restart && (win || lose) && score_from_reg > hiscore)
            hiscore <= score_from_reg;
    end
`else
    logic unused_end_pulse;
    assign unused_end_pulse = win | lose;
    assign hiscore          = '0;
`endif

endmodule

// File: tb/tb_game_state_regs.sv
// Directed bench for game_state_regs with TIME_FRAMES=3 and SCORE_W=10.
// Covers loads, lives saturation, countdown, BCD conversion/pending/abort, hiscore.
module tb_game_state_regs;

    localparam int SCORE_W = 10;

    logic               Clk = 1'b0;
    logic               Reset, restart, frame_clk, timer_en;
    logic               Load_S, Load_F, Load_L;
    logic [SCORE_W-1:0] score_to_reg;
    logic [3:0]         fruits_to_reg;
    logic [7:0]         lives_to_reg;
    logic               win, lose;
    logic [SCORE_W-1:0] score_from_reg;
    logic [3:0]         fruits_from_reg;
    logic [1:0]         lives_from_reg;
    logic [31:0]        counter;
    logic [15:0]        score_bcd;
    logic               bcd_busy;
    logic [SCORE_W-1:0] hiscore;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] prev_bcd;
    logic [31:0] exp_cnt[5];

    game_state_regs #(.TIME_FRAMES(32'd3), .SCORE_W(SCORE_W)) dut (
        .Clk(Clk), .Reset(Reset), .restart(restart), .frame_clk(frame_clk),
        .timer_en(timer_en), .Load_S(Load_S), .Load_F(Load_F), .Load_L(Load_L),
        .score_to_reg(score_to_reg), .fruits_to_reg(fruits_to_reg),
        .lives_to_reg(lives_to_reg), .win(win), .lose(lose),
        .score_from_reg(score_from_reg), .fruits_from_reg(fruits_from_reg),
        .lives_from_reg(lives_from_reg), .counter(counter), .score_bcd(score_bcd),
        .bcd_busy(bcd_busy), .hiscore(hiscore)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_pulse();
        @(negedge Clk); frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic load_score(input logic [SCORE_W-1:0] v);
        @(negedge Clk); Load_S = 1'b1; score_to_reg = v;
        @(negedge Clk); Load_S = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; restart = 1'b0; frame_clk = 1'b0; timer_en = 1'b0;
        Load_S = 1'b0; Load_F = 1'b0; Load_L = 1'b0;
        score_to_reg = '0; fruits_to_reg = '0; lives_to_reg = '0;
        win = 1'b0; lose = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("rst_score",   score_from_reg, 0);
        check("rst_fruits",  fruits_from_reg, 0);
        check("rst_lives",   lives_from_reg, 0);
        check("rst_counter", counter, 3);
        check("rst_bcd",     score_bcd, 0);
        check("rst_busy",    bcd_busy, 0);
        check("rst_hiscore", hiscore, 0);

        // Single conversion: 523 -> 0x0523 after SCORE_W+2 cycles
        load_score(10'd523);
        check("t1_score", score_from_reg, 523);
        @(negedge Clk);
        check("t1_busy_start", bcd_busy, 1);
        repeat (10) @(negedge Clk);
        check("t1_bcd_before", score_bcd, 16'h0000);
        check("t1_busy_mid", bcd_busy, 1);
        @(negedge Clk);
        check("t1_bcd", score_bcd, 16'h0523);
        check("t1_busy_end", bcd_busy, 0);

        // Loads with saturating lives
        @(negedge Clk); Load_F = 1'b1; fruits_to_reg = 4'hA; Load_L = 1'b1; lives_to_reg = 8'd7;
        @(negedge Clk); Load_F = 1'b0; Load_L = 1'b0;
        check("t2_fruits", fruits_from_reg, 4'hA);
        check("t2_lives_sat", lives_from_reg, 3);
        @(negedge Clk); Load_L = 1'b1; lives_to_reg = 8'd2;
        @(negedge Clk); Load_L = 1'b0;
        check("t2_lives_2", lives_from_reg, 2);
        @(negedge Clk); Load_L = 1'b1; lives_to_reg = 8'd200;
        @(negedge Clk); Load_L = 1'b0;
        check("t2_lives_200", lives_from_reg, 3);
        check("t2_score_kept", score_from_reg, 523);

        // Countdown: disabled tick dropped, then 3 -> 2,1,0,0,0
        frame_pulse();
        check("t3_frozen", counter, 3);
        timer_en = 1'b1;
        exp_cnt = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            frame_pulse();
            check($sformatf("t3_count%0d", i), counter, exp_cnt[i]);
        end
        timer_en = 1'b0;

        // Back-to-back scores: only 0999 then 0050 may appear
        exp_q.push_back(16'h0999);
        exp_q.push_back(16'h0050);
        prev_bcd = score_bcd;
        load_score(10'd999);
        load_score(10'd50);
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (score_bcd !== prev_bcd) begin
                got_q.push_back(score_bcd);
                prev_bcd = score_bcd;
            end
        end
        check("t4_nchanges", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("t4_value%0d", i), got_q[i], exp_q[i]);
        check("t4_busy_end", bcd_busy, 0);

        // restart mid-conversion, with a same-cycle load
        load_score(10'd777);
        repeat (4) @(negedge Clk);
        restart = 1'b1; Load_S = 1'b1; score_to_reg = 10'd100;
        @(negedge Clk); restart = 1'b0; Load_S = 1'b0;
        check("t5_score", score_from_reg, 0);
        check("t5_counter", counter, 3);
        check("t5_bcd", score_bcd, 0);
        check("t5_busy", bcd_busy, 0);
        check("t5_fruits", fruits_from_reg, 0);
        check("t5_lives", lives_from_reg, 0);
        repeat (15) @(negedge Clk);
        check("t5_bcd_later", score_bcd, 0);

        // Hiscore
        load_score(10'd300);
        lose = 1'b1;
        @(negedge Clk); lose = 1'b0;
`ifdef HISCORE_EN
        check("t6_hi_300", hiscore, 300);
        restart = 1'b1;
        @(negedge Clk); restart = 1'b0;
        check("t6_hi_restart", hiscore, 300);
        load_score(10'd200);
        win = 1'b1;
        @(negedge Clk); win = 1'b0;
        check("t6_hi_keep", hiscore, 300);
`else
        check("t6_hi_off", hiscore, 0);
`endif
        Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        check("t6_hi_reset", hiscore, 0);
        check("t6_score_reset", score_from_reg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
